// File: rtl/fcmp_minmax_pipe_if.sv
// Request/response bundle for the FP compare/min-max/classify unit.
// The master drives requests and accepts results; the slave is the execution unit.
interface fcmp_minmax_pipe_if #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 6
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [31:0]      in_rs1;
    logic [31:0]      in_rs2;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_res;
    logic [4:0]       out_fflags;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_op, in_rs1, in_rs2, in_tag, out_ready,
        input  in_ready, out_valid, out_res, out_fflags, out_tag
    );

    modport slave (
        input  in_valid, in_op, in_rs1, in_rs2, in_tag, out_ready,
        output in_ready, out_valid, out_res, out_fflags, out_tag
    );
endinterface

// File: rtl/fcmp_minmax_pipe.sv
// Two-stage FEQ/FLT/FLE/FMIN/FMAX/FCLASS (single precision) execution unit.
// Stage 1 registers operands and their class masks; stage 2 registers result and fflags.
module fclassifier #(
    parameter int EXPWIDTH = 8,
    parameter int SIGWIDTH = 24
) (
    input  logic [EXPWIDTH+SIGWIDTH-1:0] operand,
    output logic [9:0]                   cls
);
    localparam int FLEN = EXPWIDTH + SIGWIDTH;

    logic sign;
    logic exp_ones;
    logic exp_zero;
    logic frac_zero;
    logic quiet;

    always_comb begin
        sign      = operand[FLEN-1];
        exp_ones  = &operand[FLEN-2 -: EXPWIDTH];
        exp_zero  = ~|operand[FLEN-2 -: EXPWIDTH];
        frac_zero = ~|operand[SIGWIDTH-2:0];
        quiet     = operand[SIGWIDTH-2];

        cls[0] =  sign & exp_ones & frac_zero;
        cls[1] =  sign & !exp_ones & !exp_zero;
        cls[2] =  sign & exp_zero & !frac_zero;
        cls[3] =  sign & exp_zero & frac_zero;
        cls[4] = !sign & exp_zero & frac_zero;
        cls[5] = !sign & exp_zero & !frac_zero;
        cls[6] = !sign & !exp_ones & !exp_zero;
        cls[7] = !sign & exp_ones & frac_zero;
        cls[8] =  exp_ones & !frac_zero & !quiet;
        cls[9] =  exp_ones & quiet;
    end
endmodule

module fcmp_minmax_pipe #(
    parameter int XLEN     = 64,
    parameter int EXPWIDTH = 8,
    parameter int SIGWIDTH = 24,
    parameter int TAG_W    = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    fcmp_minmax_pipe_if.slave   bus
);
    localparam int FLEN = EXPWIDTH + SIGWIDTH;
    localparam logic [FLEN-1:0] CANON_NAN =
        {1'b0, {EXPWIDTH{1'b1}}, 1'b1, {(SIGWIDTH-2){1'b0}}};

    typedef enum logic [2:0] {
        OP_FEQ    = 3'd0,
        OP_FLT    = 3'd1,
        OP_FLE    = 3'd2,
        OP_FMIN   = 3'd3,
        OP_FMAX   = 3'd4,
        OP_FCLASS = 3'd5,
        OP_RSV6   = 3'd6,
        OP_RSV7   = 3'd7
    } fop_e;

    // Handshake
    logic s1_valid;
    logic s2_valid;
    logic s1_load;
    logic s2_load;
    logic in_ready;
    logic accept;

    // Stage 1
    fop_e             s1_op;
    logic [FLEN-1:0]  s1_a;
    logic [FLEN-1:0]  s1_b;
    logic [TAG_W-1:0] s1_tag;
    logic [9:0]       s1_cls_a;
    logic [9:0]       s1_cls_b;
    logic [9:0]       cls_a;
    logic [9:0]       cls_b;

    // Stage 2
    logic [XLEN-1:0]  out_res_q;
    logic [4:0]       out_fflags_q;
    logic [TAG_W-1:0] out_tag_q;

    // Compare datapath
    logic            a_nan, b_nan, any_nan, any_snan;
    logic            neg_a, neg_b, pos_a, pos_b;
    logic            both_zero;
    logic            eq, lt;
    logic            pick_a;
    logic [FLEN-1:0] minmax;
    logic [XLEN-1:0] res_d;
    logic            nv_d;

    fclassifier #(.EXPWIDTH(EXPWIDTH), .SIGWIDTH(SIGWIDTH)) u_cls_a (
        .operand (bus.in_rs1[FLEN-1:0]),
        .cls     (cls_a)
    );

    fclassifier #(.EXPWIDTH(EXPWIDTH), .SIGWIDTH(SIGWIDTH)) u_cls_b (
        .operand (bus.in_rs2[FLEN-1:0]),
        .cls     (cls_b)
    );

    always_comb begin
        s2_load  = !s2_valid | bus.out_ready;
        s1_load  = !s1_valid | s2_load;
        in_ready = s1_load & !flush;
        accept   = bus.in_valid & in_ready;
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = s2_valid;
    assign bus.out_res    = out_res_q;
    assign bus.out_fflags = out_fflags_q;
    assign bus.out_tag    = out_tag_q;

    // Sign is taken from the class mask; for NaN both flags are 0, which is harmless
    // because every NaN case is overridden before the ordering result is used.
    always_comb begin
        a_nan     = s1_cls_a[8] | s1_cls_a[9];
        b_nan     = s1_cls_b[8] | s1_cls_b[9];
        any_nan   = a_nan | b_nan;
        any_snan  = s1_cls_a[8] | s1_cls_b[8];
        neg_a     = |s1_cls_a[3:0];
        neg_b     = |s1_cls_b[3:0];
        pos_a     = |s1_cls_a[7:4];
        pos_b     = |s1_cls_b[7:4];
        both_zero = (s1_cls_a[3] | s1_cls_a[4]) & (s1_cls_b[3] | s1_cls_b[4]);
        eq        = both_zero | (s1_a == s1_b);
        lt        = !both_zero &
                    ((neg_a & pos_b) |
                     (neg_a & neg_b & (s1_b[FLEN-2:0] < s1_a[FLEN-2:0])) |
                     (pos_a & pos_b & (s1_a[FLEN-2:0] < s1_b[FLEN-2:0])));
    end

    // On a tie (including -0 vs +0) FMIN takes the negative operand, FMAX the other.
    always_comb begin
        pick_a = (lt | (eq & neg_a)) ^ (s1_op == OP_FMAX);
        if (a_nan & b_nan) begin
            minmax = CANON_NAN;
        end else if (a_nan) begin
            minmax = s1_b;
        end else if (b_nan) begin
            minmax = s1_a;
        end else if (pick_a) begin
            minmax = s1_a;
        end else begin
            minmax = s1_b;
        end
    end

    always_comb begin
        res_d = '0;
        nv_d  = 1'b0;
        case (s1_op)
            OP_FEQ: begin
                res_d[0] = !any_nan & eq;
                nv_d     = any_snan;
            end
            OP_FLT: begin
                res_d[0] = !any_nan & lt;
                nv_d     = any_nan;
            end
            OP_FLE: begin
                res_d[0] = !any_nan & (lt | eq);
                nv_d     = any_nan;
            end
            OP_FMIN, OP_FMAX: begin
                res_d           = '1;
                res_d[FLEN-1:0] = minmax;
                nv_d            = any_snan;
            end
            OP_FCLASS: begin
                res_d[9:0] = s1_cls_a;
            end
            default: begin
                res_d = '0;
                nv_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid     <= 1'b0;
            s2_valid     <= 1'b0;
            s1_op        <= OP_FEQ;
            s1_a         <= '0;
            s1_b         <= '0;
            s1_tag       <= '0;
            s1_cls_a     <= '0;
            s1_cls_b     <= '0;
            out_res_q    <= '0;
            out_fflags_q <= '0;
            out_tag_q    <= '0;
        end else if (flush) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (s2_load) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    out_res_q    <= res_d;
                    out_fflags_q <= {nv_d, 4'b0000};
                    out_tag_q    <= s1_tag;
                end
            end
            if (s1_load) begin
                s1_valid <= accept;
                if (accept) begin
                    s1_op    <= fop_e'(bus.in_op);
                    s1_a     <= bus.in_rs1[FLEN-1:0];
                    s1_b     <= bus.in_rs2[FLEN-1:0];
                    s1_tag   <= bus.in_tag;
                    s1_cls_a <= cls_a;
                    s1_cls_b <= cls_b;
                end
            end
        end
    end
endmodule

// File: tb/tb_fcmp_minmax_pipe.sv
// Randomized and directed bench for fcmp_minmax_pipe against a field-level FP reference model.
module tb_fcmp_minmax_pipe;
    logic clk = 1'b0;
    logic rst;
    logic flush;

    fcmp_minmax_pipe_if #(.XLEN(64), .TAG_W(6)) bus ();

    fcmp_minmax_pipe #(.XLEN(64), .EXPWIDTH(8), .SIGWIDTH(24), .TAG_W(6)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] res;
        logic [4:0]  ff;
    } result_t;

    typedef struct {
        logic [63:0] res;
        logic [4:0]  ff;
        logic [5:0]  tag;
        int unsigned cyc;
    } sb_t;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned cyc      = 0;
    sb_t         sbq[$];
    logic        lat_check = 1'b0;
    logic [5:0]  next_tag  = 6'd0;

    logic        hold = 1'b0;
    logic [63:0] hold_res;
    logic [4:0]  hold_ff;
    logic [5:0]  hold_tag;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: IEEE fields decoded directly, ordering via a signed integer key.
    function automatic bit is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    function automatic bit is_snan(input logic [31:0] x);
        return is_nan(x) && !x[22];
    endfunction

    function automatic longint fkey(input logic [31:0] x);
        longint m;
        m = longint'(x[30:0]);
        return x[31] ? -m : m;
    endfunction

    function automatic int class_idx(input logic [31:0] x);
        if (is_nan(x))                               return is_snan(x) ? 8 : 9;
        if (x[30:23] == 8'hFF)                       return x[31] ? 0 : 7;
        if (x[30:23] == 8'd0 && x[22:0] == 23'd0)    return x[31] ? 3 : 4;
        if (x[30:23] == 8'd0)                        return x[31] ? 2 : 5;
        return x[31] ? 1 : 6;
    endfunction

    function automatic result_t ref_exec(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        result_t r;
        bit      na, nb, sn;
        longint  ka, kb;
        logic [31:0] m;
        na = is_nan(a);
        nb = is_nan(b);
        sn = is_snan(a) || is_snan(b);
        ka = fkey(a);
        kb = fkey(b);
        r.res = 64'd0;
        r.ff  = 5'd0;
        m = 32'd0;
        case (op)
            3'd0: begin r.res = 64'(!(na || nb) && ka == kb); r.ff = sn ? 5'h10 : 5'h00; end
            3'd1: begin r.res = 64'(!(na || nb) && ka <  kb); r.ff = (na || nb) ? 5'h10 : 5'h00; end
            3'd2: begin r.res = 64'(!(na || nb) && ka <= kb); r.ff = (na || nb) ? 5'h10 : 5'h00; end
            3'd3, 3'd4: begin
                if (na && nb)                m = 32'h7FC00000;
                else if (na)                 m = b;
                else if (nb)                 m = a;
                else if (op == 3'd3)         m = (ka < kb) ? a : (kb < ka) ? b : (a[31] ? a : b);
                else                         m = (ka > kb) ? a : (kb > ka) ? b : (a[31] ? b : a);
                r.res = {32'hFFFFFFFF, m};
                r.ff  = sn ? 5'h10 : 5'h00;
            end
            3'd5: r.res = 64'd1 << class_idx(a);
            default: ;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] special(input int unsigned i);
        case (i)
            0: return 32'h00000000;  1: return 32'h80000000;
            2: return 32'h7F800000;  3: return 32'hFF800000;
            4: return 32'h7FC00000;  5: return 32'h7FA00000;
            6: return 32'hFF800001;  7: return 32'h00000001;
            8: return 32'h80000001;  9: return 32'h3F800000;
            10: return 32'hBF800000; default: return 32'h7F7FFFFF;
        endcase
    endfunction

    function automatic logic [31:0] rand_operand(input logic [31:0] other);
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 9))
            0, 1, 2, 3: return r;
            4, 5:       return special($urandom_range(0, 11));
            6:          return other;
            7:          return other ^ 32'h80000000;
            8:          return {other[31:23], r[22:0]};
            default:    return other + {28'd0, r[3:0]};
        endcase
    endfunction

    // Scoreboard/monitor, sampled on the falling edge: it records what the next rising edge will do.
    always @(negedge clk) begin
        sb_t     e;
        result_t m;
        cyc++;
        if (rst) begin
            sbq.delete();
            hold = 1'b0;
        end else begin
            if (hold) begin
                check("hold_valid", 64'(bus.out_valid), 64'd1);
                check("hold_res", bus.out_res, hold_res);
                check("hold_fflags", 64'(bus.out_fflags), 64'(hold_ff));
                check("hold_tag", 64'(bus.out_tag), 64'(hold_tag));
            end
            hold     = bus.out_valid && !bus.out_ready && !flush;
            hold_res = bus.out_res;
            hold_ff  = bus.out_fflags;
            hold_tag = bus.out_tag;
            if (flush) begin
                sbq.delete();
            end else begin
                if (bus.out_valid && bus.out_ready) begin
                    if (sbq.size() == 0) begin
                        check("unexpected_out", 64'd1, 64'd0);
                    end else begin
                        e = sbq.pop_front();
                        check("res", bus.out_res, e.res);
                        check("fflags", 64'(bus.out_fflags), 64'(e.ff));
                        check("tag", 64'(bus.out_tag), 64'(e.tag));
                        if (lat_check) check("latency", 64'(cyc - e.cyc), 64'd2);
                    end
                end
                if (bus.in_valid && bus.in_ready) begin
                    m     = ref_exec(bus.in_op, bus.in_rs1, bus.in_rs2);
                    e.res = m.res;
                    e.ff  = m.ff;
                    e.tag = bus.in_tag;
                    e.cyc = cyc;
                    sbq.push_back(e);
                end
            end
        end
    end

    task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic ok;
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_rs1   = a;
        bus.in_rs2   = b;
        bus.in_tag   = next_tag;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = bus.in_ready;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        next_tag++;
        if (!ok) check("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic do_dir(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] er, input logic [4:0] ef);
        logic seen;
        send(op, a, b);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = bus.out_valid;
        end
        check({name, "_valid"}, 64'(seen), 64'd1);
        check({name, "_res"}, bus.out_res, er);
        check({name, "_ff"}, 64'(bus.out_fflags), 64'(ef));
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int unsigned acc;
        logic [31:0] ra;
        rst           = 1'b1;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_op     = 3'd0;
        bus.in_rs1    = 32'd0;
        bus.in_rs2    = 32'd0;
        bus.in_tag    = 6'd0;
        bus.out_ready = 1'b0;
        #12;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_res", bus.out_res, 64'd0);
        check("rst_out_fflags", 64'(bus.out_fflags), 64'd0);
        check("rst_out_tag", 64'(bus.out_tag), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;

        do_dir("feq_zero",  3'd0, 32'h80000000, 32'h00000000, 64'd1, 5'h00);
        do_dir("flt_zero",  3'd1, 32'h80000000, 32'h00000000, 64'd0, 5'h00);
        do_dir("flt_snan",  3'd1, 32'h7F800001, 32'h3F800000, 64'd0, 5'h10);
        do_dir("feq_qnan",  3'd0, 32'h7FC00000, 32'h3F800000, 64'd0, 5'h00);
        do_dir("fmin_nan2", 3'd3, 32'h7FC00000, 32'h7FA00000, 64'hFFFFFFFF_7FC00000, 5'h10);
        do_dir("fmax_nan1", 3'd4, 32'h7FC00000, 32'hC0000000, 64'hFFFFFFFF_C0000000, 5'h00);
        do_dir("fmin_z",    3'd3, 32'h00000000, 32'h80000000, 64'hFFFFFFFF_80000000, 5'h00);
        do_dir("fmax_z",    3'd4, 32'h80000000, 32'h00000000, 64'hFFFFFFFF_00000000, 5'h00);
        do_dir("fle_neg",   3'd2, 32'hC0000000, 32'hBF800000, 64'd1, 5'h00);
        do_dir("fcls_ninf", 3'd5, 32'hFF800000, 32'h0, 64'h1, 5'h00);
        do_dir("fcls_sub",  3'd5, 32'h00000001, 32'h0, 64'h20, 5'h00);
        do_dir("fcls_snan", 3'd5, 32'h7F800001, 32'h0, 64'h100, 5'h00);
        do_dir("fcls_qnan", 3'd5, 32'h7FC00000, 32'h0, 64'h200, 5'h00);
        do_dir("rsv6",      3'd6, 32'h3F800000, 32'h3F800000, 64'd0, 5'h00);

        // Back-to-back stream: one result per cycle, two cycles after each accept
        lat_check = 1'b1;
        for (int i = 0; i < 4; i++) send(3'(i), 32'h3F800000 + 32'(i), 32'h3F800002);
        idle(4);
        lat_check = 1'b0;
        check("stream_drain", 64'(sbq.size()), 64'd0);

        // Backpressure: only two ops fit
        bus.out_ready = 1'b0;
        acc = 0;
        bus.in_valid = 1'b1;
        bus.in_op    = 3'd3;
        bus.in_rs1   = 32'h40400000;
        bus.in_rs2   = 32'hC0400000;
        for (int i = 0; i < 5; i++) begin
            bus.in_tag = next_tag;
            @(negedge clk);
            if (bus.in_ready) acc++;
            @(posedge clk);
            #1;
            if (acc > 0) next_tag++;
        end
        @(negedge clk);
        check("bp_in_ready", 64'(bus.in_ready), 64'd0);
        check("bp_accepts", 64'(acc), 64'd2);
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        idle(4);
        check("bp_drain", 64'(sbq.size()), 64'd0);

        // Flush with two ops in flight
        send(3'd4, 32'h3F800000, 32'h40000000);
        send(3'd3, 32'h3F800000, 32'h40000000);
        flush        = 1'b1;
        bus.in_valid = 1'b1;
        @(negedge clk);
        check("flush_in_ready", 64'(bus.in_ready), 64'd0);
        @(posedge clk);
        #1;
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("flush_no_out", 64'(bus.out_valid), 64'd0);
        end
        @(posedge clk);
        #1;

        // Asynchronous reset mid-stream
        bus.out_ready = 1'b0;
        send(3'd4, 32'h3F800000, 32'h40000000);
        send(3'd4, 32'h40400000, 32'h40000000);
        #2;
        rst = 1'b1;
        #1;
        check("arst_out_valid", 64'(bus.out_valid), 64'd0);
        check("arst_out_res", bus.out_res, 64'd0);
        check("arst_out_fflags", 64'(bus.out_fflags), 64'd0);
        check("arst_out_tag", 64'(bus.out_tag), 64'd0);
        check("arst_in_ready", 64'(bus.in_ready), 64'd1);
        #4;
        rst = 1'b0;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        idle(3);
        check("arst_no_out", 64'(bus.out_valid), 64'd0);

        // Randomized traffic with random backpressure and occasional flush
        ra = 32'h3F800000;
        for (int i = 0; i < 600; i++) begin
            bus.in_valid  = ($urandom_range(0, 9) < 7);
            bus.in_op     = 3'($urandom_range(0, 7));
            ra            = rand_operand(ra);
            bus.in_rs1    = ra;
            bus.in_rs2    = rand_operand(ra);
            bus.in_tag    = next_tag;
            next_tag++;
            bus.out_ready = ($urandom_range(0, 3) != 0);
            flush         = ($urandom_range(0, 49) == 0);
            @(posedge clk);
            #1;
        end
        bus.in_valid  = 1'b0;
        flush         = 1'b0;
        bus.out_ready = 1'b1;
        idle(5);
        check("final_drain", 64'(sbq.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
